// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder: op encoding and stage count.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int num_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// SEG-bit ripple-carry segment: sum, carry out, and carry into the MSB (for overflow).
// Purely combinational; the pipeline registers live in the parent.
module adder_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cmsb
);

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG:0]   c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s    = p ^ c[SEG-1:0];
    co   = c[SEG];
    cmsb = c[SEG-1];
  end

endmodule

// File: rtl/adder_pipe_seg.sv
// Carry-pipelined adder/subtractor resolving SEG bits per stage; latency WIDTH/SEG cycles.
// Valid/ready with a single global advance: any stall at the output freezes every stage.
module adder_pipe_seg
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = num_stages(WIDTH, SEG);

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // SUB is folded into the operands once, so op/cin never travel down the pipe.
  assign b_eff    = (op == OP_SUB) ? ~b : b;
  assign c_eff    = (op == OP_SUB) ? ~cin : cin;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance & !rst;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic             vin;
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] sin;
    logic             ci_k;
    logic [SEG-1:0]   seg_s;
    logic             seg_co;
    logic             seg_cm;
    logic [WIDTH-1:0] s_nxt;

    logic             vld_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             o_q;

    if (k == 0) begin : g_first
      assign vin  = in_valid;
      assign ain  = a;
      assign bin  = b_eff;
      assign sin  = '0;
      assign ci_k = c_eff;
    end else begin : g_next
      assign vin  = g_stg[k-1].vld_q;
      assign ain  = g_stg[k-1].a_q;
      assign bin  = g_stg[k-1].b_q;
      assign sin  = g_stg[k-1].s_q;
      assign ci_k = g_stg[k-1].c_q;
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a    (ain[k*SEG +: SEG]),
      .b    (bin[k*SEG +: SEG]),
      .ci   (ci_k),
      .s    (seg_s),
      .co   (seg_co),
      .cmsb (seg_cm)
    );

    always_comb begin
      s_nxt               = sin;
      s_nxt[k*SEG +: SEG] = seg_s;
    end

    // Operands skew forward untouched; resolved sum bits accumulate in s_q.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
        s_q   <= '0;
        c_q   <= 1'b0;
        o_q   <= 1'b0;
      end else if (advance) begin
        vld_q <= vin;
        a_q   <= ain;
        b_q   <= bin;
        s_q   <= s_nxt;
        c_q   <= seg_co;
        o_q   <= seg_cm ^ seg_co;
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].vld_q;
  assign sum       = g_stg[NSTG-1].s_q;
  assign cout      = g_stg[NSTG-1].c_q;
  assign ovf       = g_stg[NSTG-1].o_q;

endmodule

// File: tb/tb_adder_pipe_seg.sv
// Bench for adder_pipe_seg: directed corner cases plus scoreboarded random traffic on (32,8) and (16,16).
module tb_adder_pipe_seg;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, op, cout, ovf;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cin16, op16, cout16, ovf16;

  int checks = 0;
  int errors = 0;
  int pops32 = 0;
  res_t q32[$];
  res_t q16[$];

  adder_pipe_seg #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  adder_pipe_seg #(.WIDTH(16), .SEG(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .op(op16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: unsigned raw sum for sum/cout, true signed result for overflow.
  function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic c, input logic o);
    longint mask, half, ua, ub, ci, raw, sa, sb, tru;
    res_t r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & mask;
    ub   = longint'(bv) & mask;
    ci   = c ? 1 : 0;
    raw  = o ? (ua + (~ub & mask) + (1 - ci)) : (ua + ub + ci);
    sa   = (ua >= half) ? ua - (half << 1) : ua;
    sb   = (ub >= half) ? ub - (half << 1) : ub;
    tru  = o ? (sa - sb - ci) : (sa + sb + ci);
    r.sum  = 32'(raw & mask);
    r.cout = raw[w];
    r.ovf  = (tru < -half) || (tru >= half);
    return r;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
    end else begin
      if (out_valid && q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb32_unexpected: out_valid=1 sum=%h with no beat outstanding", sum);
      end else if (out_valid) begin
        checks++;
        if ({sum, cout, ovf} !== {q32[0].sum, q32[0].cout, q32[0].ovf}) begin
          errors++;
          $display("FAIL sb32_data: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b (ready=%b)",
                   sum, cout, ovf, q32[0].sum, q32[0].cout, q32[0].ovf, out_ready);
        end
        if (out_ready) begin
          void'(q32.pop_front());
          pops32++;
        end
      end
      if (in_valid && in_ready) q32.push_back(model(32, a, b, cin, op));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
    end else begin
      if (out_valid16 && q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb16_unexpected: out_valid=1 sum=%h with no beat outstanding", sum16);
      end else if (out_valid16) begin
        checks++;
        if ({16'h0, sum16, cout16, ovf16} !== {q16[0].sum, q16[0].cout, q16[0].ovf}) begin
          errors++;
          $display("FAIL sb16_data: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   sum16, cout16, ovf16, q16[0].sum[15:0], q16[0].cout, q16[0].ovf);
        end
        if (out_ready16) void'(q16.pop_front());
      end
      if (in_valid16 && in_ready16) q16.push_back(model(16, {16'h0, a16}, {16'h0, b16}, cin16, op16));
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; op = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; op16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, sum, cout, ovf} !== 35'h0) begin
      errors++;
      $display("FAIL reset_state: got vld=%b sum=%h cout=%b ovf=%b want all zero", out_valid, sum, cout, ovf);
    end
    checks++;
    if (in_ready !== 1'b0 || in_ready16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready, in_ready16);
    end
    checks++;
    if (out_valid16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state16: got out_valid=%b want 0", out_valid16);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic send_one(input string nm, input logic [31:0] av, input logic [31:0] bv,
                          input logic c, input logic o,
                          input logic [31:0] es, input logic ec, input logic eo);
    int cnt;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; a = av; b = bv; cin = c; op = o;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%b want 1", nm, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv; cin = ~c; op = ~o;
    cnt = 1;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles want 4", nm, cnt);
    end
    checks++;
    if ({sum, cout, ovf} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               nm, sum, cout, ovf, es, ec, eo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    send_one("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send_one("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    send_one("sub_borrow",32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    send_one("add_cin",   32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send_one("sub_bin",   32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int p0;
    int wait_cyc;
    p0 = pops32;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          in_valid = 1'b1;
          a = 32'h0101_0101 * i;
          b = 32'hFFFF_FF00 + i;
          op = i[0];
          cin = i[1];
          wait_cyc = 0;
          @(negedge clk);
          while (!in_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
          end
          if (wait_cyc >= 50) begin
            checks++; errors++;
            $display("FAIL b2b_accept_timeout: beat %0d never accepted", i);
          end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_cyc = 0;
    while ((q32.size() != 0 || out_valid) && wait_cyc < 50) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    checks++;
    if (pops32 - p0 != 8 || q32.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d results (%0d outstanding) want 8 (0)", pops32 - p0, q32.size());
    end
  endtask

  task automatic test_reset_flush();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1;
      a = 32'hA5A5_0000 + i; b = 32'h0F0F_0F0F; cin = 1'b0; op = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_next_cycle: out_valid=%b want 0", out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_stale: cycle %0d out_valid=%b want 0", i, out_valid);
      end
    end
    send_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
  endtask

  task automatic rand_run32(input int n);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 40000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick32();
      b         = pick32();
      cin       = 1'($urandom_range(0, 1));
      op        = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      cyc++;
    end
    checks++;
    if (acc < n) begin
      errors++;
      $display("FAIL rand32_progress: accepted %0d want %0d", acc, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (q32.size() != 0 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (q32.size() != 0) begin
      errors++;
      $display("FAIL rand32_drain: %0d outstanding want 0", q32.size());
    end
  endtask

  task automatic rand_run16(input int n);
    int acc = 0;
    int cyc = 0;
    logic [31:0] t;
    while (acc < n && cyc < 40000) begin
      @(posedge clk); #1;
      in_valid16  = ($urandom_range(0, 3) != 0);
      t = pick32(); a16 = t[31:16] ^ t[15:0];
      t = pick32(); b16 = t[15:0];
      cin16       = 1'($urandom_range(0, 1));
      op16        = 1'($urandom_range(0, 1));
      out_ready16 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid16 && in_ready16) acc++;
      cyc++;
    end
    checks++;
    if (acc < n) begin
      errors++;
      $display("FAIL rand16_progress: accepted %0d want %0d", acc, n);
    end
    @(posedge clk); #1;
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    cyc = 0;
    while (q16.size() != 0 && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (q16.size() != 0) begin
      errors++;
      $display("FAIL rand16_drain: %0d outstanding want 0", q16.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    fork
      rand_run32(10000);
      rand_run16(10000);
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
